// File: rtl/lif_neuron_pkg.sv
// -----------------------------------------------------------------------------
// lif_neuron_pkg
// Shared types and arithmetic helpers for the LIF neuron array.
//   state_t    : sequencer states of the time-multiplexed datapath
//   DECAY_MULT : decay mode 0, v - (v >>> DECAY_SHIFT)
//   DECAY_SUB  : decay mode 1, linear leak toward zero by LEAK
//   sat_add    : signed add that clamps to the range of a w-bit signed value
// -----------------------------------------------------------------------------
package lif_neuron_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        UPDATE = 2'd2,
        EMIT   = 2'd3
    } state_t;

    localparam int DECAY_MULT = 0;
    localparam int DECAY_SUB  = 1;

    // Operands arrive sign-extended to 64 bits; w is the width the caller
    // keeps (w <= 63). The 65-bit sum cannot overflow, so the clamp is exact.
    function automatic logic signed [63:0] sat_add(
        input logic signed [63:0] a,
        input logic signed [63:0] b,
        input int                 w
    );
        logic signed [64:0] sum;
        logic signed [64:0] hi;
        logic signed [64:0] lo;
        sum = $signed({a[63], a}) + $signed({b[63], b});
        hi  = (65'sd1 <<< (w - 1)) - 65'sd1;
        lo  = -(65'sd1 <<< (w - 1));
        if (sum > hi) begin
            return hi[63:0];
        end else if (sum < lo) begin
            return lo[63:0];
        end else begin
            return sum[63:0];
        end
    endfunction

endpackage

// File: rtl/lif_neuron_array_update.sv
// -----------------------------------------------------------------------------
// lif_update
// Combinational membrane update for one neuron: decay, integrate the step's
// accumulated input, compare against threshold, run the refractory counter.
// A single instance is shared by all neurons through the serial datapath.
//   pot         : current membrane potential
//   acc         : synaptic input accumulated during the step
//   refrac      : remaining refractory steps
//   pot_next    : potential to store back
//   refrac_next : refractory count to store back
//   fire        : neuron fires this step
// -----------------------------------------------------------------------------
module lif_update
    import lif_neuron_pkg::*;
#(
    parameter int POT_W        = 32,
    parameter int DECAY_MODE   = 0,
    parameter int DECAY_SHIFT  = 2,
    parameter int LEAK         = 8,
    parameter int THRESHOLD    = 1000,
    parameter int V_RESET      = 0,
    parameter int REFRAC_STEPS = 2,
    parameter int REF_W        = 2
) (
    input  logic signed [POT_W-1:0] pot,
    input  logic signed [POT_W-1:0] acc,
    input  logic [REF_W-1:0]        refrac,
    output logic signed [POT_W-1:0] pot_next,
    output logic [REF_W-1:0]        refrac_next,
    output logic                    fire
);

    localparam logic signed [POT_W-1:0] THR         = POT_W'(THRESHOLD);
    localparam logic signed [POT_W-1:0] VRST        = POT_W'(V_RESET);
    localparam logic signed [POT_W-1:0] LEAK_V      = POT_W'(LEAK);
    localparam logic [REF_W-1:0]        REFRAC_INIT = REF_W'(REFRAC_STEPS);

    logic signed [POT_W-1:0] decayed;
    logic signed [POT_W-1:0] integ;

    // Mode 0 cannot overflow: v >>> s has the sign of v and no larger magnitude.
    // Mode 1 clamps at zero so the leak never pushes the potential past it.
    always_comb begin
        decayed = pot;
        if (DECAY_MODE == DECAY_MULT) begin
            decayed = pot - (pot >>> DECAY_SHIFT);
        end else if (DECAY_MODE == DECAY_SUB) begin
            if (pot > LEAK_V) begin
                decayed = pot - LEAK_V;
            end else if (pot < -LEAK_V) begin
                decayed = pot + LEAK_V;
            end else begin
                decayed = '0;
            end
        end
    end

    assign integ = POT_W'(sat_add(64'(decayed), 64'(acc), POT_W));

    always_comb begin
        pot_next    = integ;
        refrac_next = '0;
        fire        = 1'b0;
        if (refrac != '0) begin
            pot_next    = VRST;
            refrac_next = refrac - REF_W'(1);
        end else if (integ >= THR) begin
            fire        = 1'b1;
            pot_next    = VRST;
            refrac_next = REFRAC_INIT;
        end
    end

endmodule

// File: rtl/lif_neuron_array.sv
// -----------------------------------------------------------------------------
// lif_neuron_array
// NUM_NEURONS leaky integrate-and-fire neurons sharing one serial datapath.
// Events (source addresses from the NoC) add the addressed weight of every
// neuron into its accumulator; a step request decays and integrates every
// neuron, then emits one spike vector for the packetiser.
//   clk, rst_n          : clock, asynchronous active-low reset (release is
//                         expected to be synchronised upstream)
//   cfg_we/cfg_ready    : weight write handshake (cfg_neuron, cfg_idx,
//                         cfg_wdata)
//   ev_valid/ev_ready   : spike event handshake, ev_addr low bits pick the
//                         weight entry
//   step_valid/step_ready : end-of-time-step handshake
//   spike_valid         : one-cycle pulse, spike_vec holds the step's fire
//                         flags until the next pulse
// Only IDLE accepts requests; priority cfg > event > step, so at most one
// handshake completes per cycle.
// -----------------------------------------------------------------------------
module lif_neuron_array
    import lif_neuron_pkg::*;
#(
    parameter int NUM_NEURONS  = 4,
    parameter int ADDR_W       = 12,
    parameter int SYN_DEPTH    = 16,
    parameter int WEIGHT_W     = 16,
    parameter int POT_W        = 32,
    parameter int DECAY_MODE   = 0,
    parameter int DECAY_SHIFT  = 2,
    parameter int LEAK         = 8,
    parameter int THRESHOLD    = 1000,
    parameter int V_RESET      = 0,
    parameter int REFRAC_STEPS = 2,
    localparam int N_W   = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int IDX_W = (SYN_DEPTH > 1) ? $clog2(SYN_DEPTH) : 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    output logic                   cfg_ready,
    input  logic [N_W-1:0]         cfg_neuron,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic [WEIGHT_W-1:0]    cfg_wdata,
    input  logic                   ev_valid,
    output logic                   ev_ready,
    input  logic [ADDR_W-1:0]      ev_addr,
    input  logic                   step_valid,
    output logic                   step_ready,
    output logic                   spike_valid,
    output logic [NUM_NEURONS-1:0] spike_vec
);

    localparam int REF_W = (REFRAC_STEPS > 0) ? $clog2(REFRAC_STEPS + 1) : 1;

    state_t                     state;
    logic [N_W-1:0]             n;
    logic [IDX_W-1:0]           idx_q;
    logic signed [WEIGHT_W-1:0] weight [NUM_NEURONS][SYN_DEPTH];
    logic signed [POT_W-1:0]    pot    [NUM_NEURONS];
    logic signed [POT_W-1:0]    acc    [NUM_NEURONS];
    logic [REF_W-1:0]           refrac [NUM_NEURONS];
    logic [NUM_NEURONS-1:0]     fire_work;
    logic [NUM_NEURONS-1:0]     fire_cur;

    logic                       last_n;
    logic signed [POT_W-1:0]    acc_sum;
    logic signed [POT_W-1:0]    upd_pot;
    logic [REF_W-1:0]           upd_refrac;
    logic                       upd_fire;

    assign cfg_ready  = (state == IDLE);
    assign ev_ready   = cfg_ready & ~cfg_we;
    assign step_ready = ev_ready & ~ev_valid;

    assign last_n  = (n == N_W'(NUM_NEURONS - 1));
    assign acc_sum = POT_W'(sat_add(64'(acc[n]), 64'(weight[n][idx_q]), POT_W));

    // Address bits above the weight index carry routing information only.
    if (ADDR_W > IDX_W) begin : g_addr_hi
        logic addr_hi_unused;
        assign addr_hi_unused = ^ev_addr[ADDR_W-1:IDX_W];
    end

    lif_update #(
        .POT_W        (POT_W),
        .DECAY_MODE   (DECAY_MODE),
        .DECAY_SHIFT  (DECAY_SHIFT),
        .LEAK         (LEAK),
        .THRESHOLD    (THRESHOLD),
        .V_RESET      (V_RESET),
        .REFRAC_STEPS (REFRAC_STEPS),
        .REF_W        (REF_W)
    ) u_update (
        .pot         (pot[n]),
        .acc         (acc[n]),
        .refrac      (refrac[n]),
        .pot_next    (upd_pot),
        .refrac_next (upd_refrac),
        .fire        (upd_fire)
    );

    // Fire flags collected so far this step, including the neuron in flight.
    always_comb begin
        fire_cur    = fire_work;
        fire_cur[n] = upd_fire;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            n           <= '0;
            idx_q       <= '0;
            fire_work   <= '0;
            spike_valid <= 1'b0;
            spike_vec   <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
                pot[i]    <= '0;
                acc[i]    <= '0;
                refrac[i] <= '0;
                for (int j = 0; j < SYN_DEPTH; j++) begin
                    weight[i][j] <= '0;
                end
            end
        end else begin
            spike_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_we) begin
                        weight[cfg_neuron][cfg_idx] <= cfg_wdata;
                    end else if (ev_valid) begin
                        idx_q <= ev_addr[IDX_W-1:0];
                        n     <= '0;
                        state <= ACCUM;
                    end else if (step_valid) begin
                        fire_work <= '0;
                        n         <= '0;
                        state     <= UPDATE;
                    end
                end
                ACCUM: begin
                    // Refractory neurons drop incoming spikes entirely.
                    if (refrac[n] == '0) begin
                        acc[n] <= acc_sum;
                    end
                    if (last_n) begin
                        state <= IDLE;
                    end else begin
                        n <= n + N_W'(1);
                    end
                end
                UPDATE: begin
                    pot[n]    <= upd_pot;
                    refrac[n] <= upd_refrac;
                    acc[n]    <= '0;
                    fire_work <= fire_cur;
                    if (last_n) begin
                        spike_vec   <= fire_cur;
                        spike_valid <= 1'b1;
                        state       <= EMIT;
                    end else begin
                        n <= n + N_W'(1);
                    end
                end
                EMIT: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron_array.sv
// -----------------------------------------------------------------------------
// tb_lif_neuron_array
// Directed bench for lif_neuron_array. dut_a uses the default parameters,
// dut_b uses POT_W=16 with the subtractive leak. Inputs change 1 time unit
// after the rising edge; outputs are read away from the edge.
// -----------------------------------------------------------------------------
module tb_lif_neuron_array;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // dut_a signals
    logic        cfg_we, cfg_ready;
    logic [1:0]  cfg_neuron;
    logic [3:0]  cfg_idx;
    logic [15:0] cfg_wdata;
    logic        ev_valid, ev_ready;
    logic [11:0] ev_addr;
    logic        step_valid, step_ready;
    logic        spike_valid;
    logic [3:0]  spike_vec;

    // dut_b signals
    logic        b_cfg_we, b_cfg_ready;
    logic [1:0]  b_cfg_neuron;
    logic [3:0]  b_cfg_idx;
    logic [15:0] b_cfg_wdata;
    logic        b_ev_valid, b_ev_ready;
    logic [11:0] b_ev_addr;
    logic        b_step_valid, b_step_ready;
    logic        b_spike_valid;
    logic [3:0]  b_spike_vec;

    lif_neuron_array dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (cfg_we),
        .cfg_ready   (cfg_ready),
        .cfg_neuron  (cfg_neuron),
        .cfg_idx     (cfg_idx),
        .cfg_wdata   (cfg_wdata),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_addr     (ev_addr),
        .step_valid  (step_valid),
        .step_ready  (step_ready),
        .spike_valid (spike_valid),
        .spike_vec   (spike_vec)
    );

    lif_neuron_array #(
        .POT_W      (16),
        .DECAY_MODE (1)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .cfg_we      (b_cfg_we),
        .cfg_ready   (b_cfg_ready),
        .cfg_neuron  (b_cfg_neuron),
        .cfg_idx     (b_cfg_idx),
        .cfg_wdata   (b_cfg_wdata),
        .ev_valid    (b_ev_valid),
        .ev_ready    (b_ev_ready),
        .ev_addr     (b_ev_addr),
        .step_valid  (b_step_valid),
        .step_ready  (b_step_ready),
        .spike_valid (b_spike_valid),
        .spike_vec   (b_spike_vec)
    );

    task automatic apply_reset();
        cfg_we = 0; cfg_neuron = 0; cfg_idx = 0; cfg_wdata = 0;
        ev_valid = 0; ev_addr = 0; step_valid = 0;
        b_cfg_we = 0; b_cfg_neuron = 0; b_cfg_idx = 0; b_cfg_wdata = 0;
        b_ev_valid = 0; b_ev_addr = 0; b_step_valid = 0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    // ---------------- dut_a drivers ----------------
    task automatic a_cfg(input logic [1:0] nrn, input logic [3:0] idx, input logic [15:0] w);
        int guard = 0;
        cfg_we = 1; cfg_neuron = nrn; cfg_idx = idx; cfg_wdata = w;
        #1;
        while (!cfg_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        checks++;
        if (!cfg_ready) begin errors++; $display("FAIL a_cfg_wait cfg_ready=%b required=1", cfg_ready); end
        @(posedge clk); #1 cfg_we = 0;
    endtask

    task automatic a_event(input logic [11:0] addr);
        int guard = 0;
        ev_valid = 1; ev_addr = addr;
        #1;
        while (!ev_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        checks++;
        if (!ev_ready) begin errors++; $display("FAIL a_event_wait ev_ready=%b required=1", ev_ready); end
        @(posedge clk); #1 ev_valid = 0;
    endtask

    // Returns the spike vector and the cycle of the pulse, counting the
    // handshake cycle as cycle 0.
    task automatic a_step(output logic [3:0] vec, output int cyc);
        int guard = 0;
        step_valid = 1;
        #1;
        while (!step_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        @(posedge clk); #1 step_valid = 0;
        cyc = 1;
        while (!spike_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
        vec = spike_vec;
        checks++;
        if (!spike_valid) begin errors++; $display("FAIL a_step_wait spike_valid=%b required=1", spike_valid); end
    endtask

    // ---------------- dut_b drivers ----------------
    task automatic b_cfg(input logic [1:0] nrn, input logic [3:0] idx, input logic [15:0] w);
        int guard = 0;
        b_cfg_we = 1; b_cfg_neuron = nrn; b_cfg_idx = idx; b_cfg_wdata = w;
        #1;
        while (!b_cfg_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        checks++;
        if (!b_cfg_ready) begin errors++; $display("FAIL b_cfg_wait cfg_ready=%b required=1", b_cfg_ready); end
        @(posedge clk); #1 b_cfg_we = 0;
    endtask

    task automatic b_event(input logic [11:0] addr);
        int guard = 0;
        b_ev_valid = 1; b_ev_addr = addr;
        #1;
        while (!b_ev_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        checks++;
        if (!b_ev_ready) begin errors++; $display("FAIL b_event_wait ev_ready=%b required=1", b_ev_ready); end
        @(posedge clk); #1 b_ev_valid = 0;
    endtask

    task automatic b_step(output logic [3:0] vec);
        int guard = 0;
        int cyc = 1;
        b_step_valid = 1;
        #1;
        while (!b_step_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        @(posedge clk); #1 b_step_valid = 0;
        while (!b_spike_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
        vec = b_spike_vec;
        checks++;
        if (!b_spike_valid) begin errors++; $display("FAIL b_step_wait spike_valid=%b required=1", b_spike_valid); end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        apply_reset();
        checks++;
        if (spike_valid !== 1'b0 || spike_vec !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got valid=%b vec=%b required 0 0000", spike_valid, spike_vec);
        end
        checks++;
        if ({cfg_ready, ev_ready, step_ready} !== 3'b111) begin
            errors++; $display("FAIL reset_ready got %b required 111", {cfg_ready, ev_ready, step_ready});
        end
        checks++;
        if (dut_a.pot[0] !== 32'sd0 || dut_a.weight[0][3] !== 16'sd0) begin
            errors++; $display("FAIL reset_state got pot0=%0d w03=%0d required 0 0", dut_a.pot[0], dut_a.weight[0][3]);
        end
    endtask

    task automatic test_fire_and_refractory();
        logic [3:0] vec;
        int cyc;
        apply_reset();
        a_cfg(2'd0, 4'd3, 16'd600);
        a_event(12'h003);
        a_event(12'h003);
        a_step(vec, cyc);
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL fire_latency got %0d required 5", cyc); end
        checks++;
        if (vec !== 4'b0001) begin errors++; $display("FAIL fire_vec got %b required 0001", vec); end
        checks++;
        if (dut_a.pot[0] !== 32'sd0 || dut_a.refrac[0] !== 2'd2 || dut_a.acc[0] !== 32'sd0) begin
            errors++; $display("FAIL fire_state got v0=%0d refrac0=%0d acc0=%0d required 0 2 0",
                               dut_a.pot[0], dut_a.refrac[0], dut_a.acc[0]);
        end
        @(posedge clk); #1;
        checks++;
        if (spike_valid !== 1'b0 || spike_vec !== 4'b0001) begin
            errors++; $display("FAIL pulse_hold got valid=%b vec=%b required 0 0001", spike_valid, spike_vec);
        end
        // Two refractory steps: events are ignored, potential pinned at reset.
        for (int i = 0; i < 2; i++) begin
            a_event(12'h003);
            repeat (5) @(posedge clk);
            #1;
            checks++;
            if (dut_a.acc[0] !== 32'sd0) begin
                errors++; $display("FAIL refrac_acc step %0d got %0d required 0", i, dut_a.acc[0]);
            end
            a_step(vec, cyc);
            checks++;
            if (vec !== 4'b0000 || dut_a.pot[0] !== 32'sd0 || dut_a.refrac[0] !== 2'(1 - i)) begin
                errors++; $display("FAIL refrac_step %0d got vec=%b v0=%0d refrac0=%0d required 0000 0 %0d",
                                   i, vec, dut_a.pot[0], dut_a.refrac[0], 1 - i);
            end
        end
        a_event(12'h003);
        a_step(vec, cyc);
        checks++;
        if (vec !== 4'b0000 || dut_a.pot[0] !== 32'sd600) begin
            errors++; $display("FAIL post_refrac got vec=%b v0=%0d required 0000 600", vec, dut_a.pot[0]);
        end
    endtask

    task automatic test_decay_mult();
        logic [3:0] vec;
        int cyc;
        logic signed [31:0] exp_v [3] = '{32'sd600, 32'sd450, 32'sd338};
        apply_reset();
        a_cfg(2'd1, 4'd0, 16'd600);
        a_event(12'h000);
        for (int i = 0; i < 3; i++) begin
            a_step(vec, cyc);
            checks++;
            if (dut_a.pot[1] !== exp_v[i] || vec !== 4'b0000) begin
                errors++; $display("FAIL decay_step %0d got v1=%0d vec=%b required %0d 0000",
                                   i, dut_a.pot[1], vec, exp_v[i]);
            end
        end
    endtask

    task automatic test_priority();
        int cyc;
        apply_reset();
        ev_valid = 1; ev_addr = 12'h000; step_valid = 1;
        #1;
        checks++;
        if (ev_ready !== 1'b1 || step_ready !== 1'b0) begin
            errors++; $display("FAIL prio_ev_step got ev_ready=%b step_ready=%b required 1 0", ev_ready, step_ready);
        end
        @(posedge clk); #1 ev_valid = 0;
        cyc = 1;
        while (!step_ready && cyc < 30) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL prio_step_delay got %0d required 5", cyc); end
        @(posedge clk); #1 step_valid = 0;
        cyc = 1;
        while (!spike_valid && cyc < 30) begin @(posedge clk); #1; cyc++; end
        checks++;
        if (cyc !== 5) begin errors++; $display("FAIL prio_step_spike got %0d required 5", cyc); end
        @(posedge clk); #1;
        cfg_we = 1; cfg_neuron = 2'd3; cfg_idx = 4'd15; cfg_wdata = 16'd5;
        ev_valid = 1; step_valid = 1;
        #1;
        checks++;
        if ({cfg_ready, ev_ready, step_ready} !== 3'b100) begin
            errors++; $display("FAIL prio_cfg got %b required 100", {cfg_ready, ev_ready, step_ready});
        end
        @(posedge clk); #1 cfg_we = 0;
        #1;
        checks++;
        if (dut_a.weight[3][15] !== 16'sd5 || ev_ready !== 1'b1) begin
            errors++; $display("FAIL cfg_write got w=%0d ev_ready=%b required 5 1", dut_a.weight[3][15], ev_ready);
        end
        ev_valid = 0; step_valid = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_saturation();
        logic [3:0] vec;
        apply_reset();
        b_cfg(2'd2, 4'd1, 16'h8000);
        b_event(12'h001);
        b_event(12'h001);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (dut_b.acc[2] !== 16'sh8000) begin
            errors++; $display("FAIL sat_acc got %0d required -32768", dut_b.acc[2]);
        end
        b_step(vec);
        checks++;
        if (dut_b.pot[2] !== 16'sh8000 || vec !== 4'b0000) begin
            errors++; $display("FAIL sat_pot got v2=%0d vec=%b required -32768 0000", dut_b.pot[2], vec);
        end
        b_step(vec);
        checks++;
        if (dut_b.pot[2] !== 16'sh8008) begin
            errors++; $display("FAIL leak_pot got v2=%0d required -32760", dut_b.pot[2]);
        end
    endtask

    task automatic test_reset_mid_update();
        int guard = 0;
        int seen = 0;
        apply_reset();
        a_cfg(2'd0, 4'd3, 16'd600);
        a_cfg(2'd1, 4'd3, 16'd300);
        a_event(12'h003);
        a_event(12'h003);
        step_valid = 1;
        #1;
        while (!step_ready && guard < 50) begin @(posedge clk); #2; guard++; end
        @(posedge clk); #1 step_valid = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (dut_a.pot[1] !== 32'sd600) begin
            errors++; $display("FAIL mid_update_v1 got %0d required 600", dut_a.pot[1]);
        end
        rst_n = 0;
        #1;
        if (spike_valid) seen++;
        repeat (3) begin @(posedge clk); #1; if (spike_valid) seen++; end
        checks++;
        if (dut_a.pot[0] !== 32'sd0 || dut_a.pot[1] !== 32'sd0 || dut_a.acc[2] !== 32'sd0) begin
            errors++; $display("FAIL reset_pots got v0=%0d v1=%0d acc2=%0d required 0 0 0",
                               dut_a.pot[0], dut_a.pot[1], dut_a.acc[2]);
        end
        rst_n = 1;
        #1;
        checks++;
        if (ev_ready !== 1'b1) begin errors++; $display("FAIL release_ev_ready got %b required 1", ev_ready); end
        repeat (8) begin @(posedge clk); #1; if (spike_valid) seen++; end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_no_spike got %0d pulses required 0", seen); end
    endtask

    initial begin
        test_reset();
        test_fire_and_refractory();
        test_decay_mult();
        test_priority();
        test_saturation();
        test_reset_mid_update();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
